alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Issuing-side controller for the 4-bit combinational ALU. It accepts instructions over a valid/ready handshake and keeps a 4-entry x 4-bit register file. For each instruction it drives the ALU operand and function-select inputs, then captures the ALU result and C/V/N/Z flags back into the register file and a status register. Sits between the top-level I/O decode and the ALU instance.

Parameters:
DATA_W, 4, operand/result width; must match the ALU width
NUM_REGS, 4, register file depth (index width = 2)
CNT_W, 8, width of the completed-operation counter

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous, active-low reset
instr_valid  input  1  instruction present on instr
instr_ready  output  1  sequencer can accept an instruction
instr  input  12  instruction word; format in Behaviour
alu_a  output  DATA_W  ALU operand A (registered)
alu_b  output  DATA_W  ALU operand B (registered)
alu_fs  output  3  ALU function select (registered)
alu_y  input  DATA_W  ALU result
alu_c, alu_v, alu_n, alu_z  input  1 each  ALU flags
rd_sel  input  2  debug read-port register index
rd_data  output  DATA_W  reg[rd_sel], combinational
flags  output  4  status register {C,V,N,Z}
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when an instruction retires
op_count  output  CNT_W  number of retired instructions

Behaviour:
- Reset: synchronous, active-low; takes effect at the next clk edge with rst_n=0. Clears all registers, flags, op_count, alu_a, alu_b, alu_fs and done to 0. State goes to IDLE. An in-flight instruction is discarded with no writeback.
- Instruction word:
  - instr[11:9] = FS.
  - instr[8] = IMM.
  - instr[7:6] = rd.
  - If IMM=0: instr[5:4] = ra, instr[3:2] = rb, instr[1:0] ignored.
  - If IMM=1: instr[3:0] = immediate; FS, ra and rb are ignored.
- States: IDLE, EXEC, WB.
- IDLE:
  - instr_ready=1, busy=0.
  - Accept on edge with instr_valid & instr_ready. The instruction is latched.
  - ALU op (IMM=0): load alu_a<=reg[ra], alu_b<=reg[rb], alu_fs<=FS; go to EXEC.
  - Immediate (IMM=1): go to WB; alu_* outputs hold their previous values.
- EXEC:
  - Exactly one cycle. The ALU settles on the registered operands.
  - At the end of the cycle, sample alu_y and the four flags into holding registers; go to WB.
- WB:
  - Write reg[rd] with the sampled alu_y (ALU op) or the immediate (IMM=1).
  - Update flags with the sampled {C,V,N,Z} for ALU ops only; immediates leave flags unchanged.
  - op_count increments, wrapping at 2^CNT_W-1 -> 0.
  - Go to IDLE.
- done: registered; high for exactly the one cycle following WB, i.e. coincident with the return to IDLE.
- Latency: accept at edge k; an ALU op writes back at edge k+2 and done is high in cycle k+2..k+3. An immediate writes back at edge k+1.
- Throughput: instr_ready=0 in EXEC and WB, so the next instruction always reads post-writeback values. No forwarding is needed.
- Aliasing: rd == ra and/or ra == rb are legal; operands are those from before the write.
- instr_valid while busy: ignored; the instruction must be held until ready.
- The sequencer never alters FS or interprets flag meaning; flags are captured exactly as presented.
- rd_data reflects register writes from the cycle after the WB edge.

Decomposition:
- Shared package:
  - State enum (IDLE/EXEC/WB).
  - Instruction field bit-position constants.
  - FS code constants used by benches (ADD=3'b000, SUB=3'b001).
  - Flag bit indices (C=3, V=2, N=1, Z=0).
- One natural sub-module, seq_regfile: NUM_REGS x DATA_W with a synchronous write port, two combinational read ports (ra, rb) plus the debug port, and synchronous reset to 0.

Test Plan:
- Reset: hold rst_n=0 for 2 edges mid-EXEC -> next cycle all regs, flags, op_count, alu_* and done read 0; state IDLE, instr_ready=1; no writeback.
- Immediates: LI r1=4'h5, then LI r2=4'h3 -> rd_data(r1)=5, rd_data(r2)=3; flags unchanged; op_count=2; each done pulse 1 cycle, 1 cycle after accept.
- ALU op with stub ALU returning y=4'h8, {C,V,N,Z}=4'b0110: ADD r3=r1,r2 (FS=000) -> alu_a=5, alu_b=3, alu_fs=000 during EXEC; r3=8 and flags=0110 after WB; done 2 cycles after accept.
- Aliasing: stub y=a-b; SUB r1=r1,r1 with r1=5 -> alu_a=alu_b=5, r1=0 after WB; flags as returned by stub.
- Backpressure: hold instr_valid=1 with a new instruction while busy -> not accepted until IDLE; exactly one retirement per instruction.
- Counter wrap: preload op_count near max via 255 immediates, issue one more -> op_count wraps 255->0, done still pulses.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// ============================================================================
// Module   : alu_sequencer_pkg
// Purpose  : Shared constants, instruction layout and state codes for the
//            ALU sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_sequencer_pkg;

    localparam int INSTR_W = 12;

    // Sequencer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    // Instruction field positions
    localparam int FS_LSB  = 9;
    localparam int IMM_BIT = 8;
    localparam int RD_LSB  = 6;
    localparam int RA_LSB  = 4;
    localparam int RB_LSB  = 2;

    // ALU function codes
    localparam logic [2:0] FS_ADD = 3'b000;
    localparam logic [2:0] FS_SUB = 3'b001;

    // Bit positions inside the {C,V,N,Z} status vector
    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    typedef struct packed {
        logic [2:0] fs;
        logic       imm;
        logic [1:0] rd;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [1:0] lo;
    } instr_t;

    // The 4-bit immediate overlays the rb field and the two unused low bits
    function automatic logic [3:0] imm_val(input instr_t ins);
        return {ins.rb, ins.lo};
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_sequencer_if.sv
// ============================================================================
// Module   : alu_sequencer_if
// Purpose  : Instruction handshake and ALU operand/result bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_sequencer_if #(
    parameter int DATA_W = 4
);
    logic              instr_valid;
    logic              instr_ready;
    logic [11:0]       instr;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_fs;
    logic [DATA_W-1:0] alu_y;
    logic              alu_c;
    logic              alu_v;
    logic              alu_n;
    logic              alu_z;

    modport slave (
        input  instr_valid, instr, alu_y, alu_c, alu_v, alu_n, alu_z,
        output instr_ready, alu_a, alu_b, alu_fs
    );

    modport master (
        output instr_valid, instr, alu_y, alu_c, alu_v, alu_n, alu_z,
        input  instr_ready, alu_a, alu_b, alu_fs
    );
endinterface

`default_nettype wire

// File: rtl/alu_sequencer_seq_regfile.sv
// ============================================================================
// Module   : seq_regfile
// Purpose  : Register file with one synchronous write port and three
//            combinational read ports (two operands plus debug).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_regfile #(
    parameter int DATA_W   = 4,
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              we_i,
    input  wire logic [IDX_W-1:0]  waddr_i,
    input  wire logic [DATA_W-1:0] wdata_i,
    input  wire logic [IDX_W-1:0]  ra_i,
    input  wire logic [IDX_W-1:0]  rb_i,
    input  wire logic [IDX_W-1:0]  dbg_i,
    output logic      [DATA_W-1:0] ra_data_o,
    output logic      [DATA_W-1:0] rb_data_o,
    output logic      [DATA_W-1:0] dbg_data_o
);
    logic [DATA_W-1:0] mem_q [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign ra_data_o  = mem_q[ra_i];
    assign rb_data_o  = mem_q[rb_i];
    assign dbg_data_o = mem_q[dbg_i];

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Issues instructions to a 4-bit combinational ALU and retires the
//            result and flags into a register file and status register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int NUM_REGS = 4,
    parameter int CNT_W    = 8
) (
    input  wire logic                        clk,
    input  wire logic                        rst_n,
    alu_sequencer_if.slave                   bus,
    input  wire logic [$clog2(NUM_REGS)-1:0] rd_sel_i,
    output logic      [DATA_W-1:0]           rd_data_o,
    output logic      [3:0]                  flags_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic      [CNT_W-1:0]            op_count_o
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]        alu_fs_q, alu_fs_d;
    logic [IDX_W-1:0]  rd_q, rd_d;
    logic              is_imm_q, is_imm_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        hold_flags_q, hold_flags_d;
    logic [3:0]        flags_q, flags_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;

    instr_t            w_instr;
    logic [DATA_W-1:0] w_ra_data, w_rb_data;
    logic              w_we;

    assign w_instr = instr_t'(bus.instr);
    assign w_we    = (state_q == ST_WB);

    seq_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (w_we),
        .waddr_i    (rd_q),
        .wdata_i    (wdata_q),
        .ra_i       (IDX_W'(w_instr.ra)),
        .rb_i       (IDX_W'(w_instr.rb)),
        .dbg_i      (rd_sel_i),
        .ra_data_o  (w_ra_data),
        .rb_data_o  (w_rb_data),
        .dbg_data_o (rd_data_o)
    );

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_fs_d     = alu_fs_q;
        rd_d         = rd_q;
        is_imm_d     = is_imm_q;
        wdata_d      = wdata_q;
        hold_flags_d = hold_flags_q;
        flags_d      = flags_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.instr_valid) begin
                    rd_d     = IDX_W'(w_instr.rd);
                    is_imm_d = w_instr.imm;
                    if (w_instr.imm) begin
                        // Immediates skip the ALU and leave its inputs untouched
                        wdata_d = DATA_W'(imm_val(w_instr));
                        state_d = ST_WB;
                    end else begin
                        alu_a_d  = w_ra_data;
                        alu_b_d  = w_rb_data;
                        alu_fs_d = w_instr.fs;
                        state_d  = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                wdata_d              = bus.alu_y;
                hold_flags_d[FLAG_C] = bus.alu_c;
                hold_flags_d[FLAG_V] = bus.alu_v;
                hold_flags_d[FLAG_N] = bus.alu_n;
                hold_flags_d[FLAG_Z] = bus.alu_z;
                state_d              = ST_WB;
            end
            ST_WB: begin
                if (!is_imm_q) begin
                    flags_d = hold_flags_q;
                end
                cnt_d   = cnt_q + CNT_W'(1);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_fs_q     <= '0;
            rd_q         <= '0;
            is_imm_q     <= 1'b0;
            wdata_q      <= '0;
            hold_flags_q <= '0;
            flags_q      <= '0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_fs_q     <= alu_fs_d;
            rd_q         <= rd_d;
            is_imm_q     <= is_imm_d;
            wdata_q      <= wdata_d;
            hold_flags_q <= hold_flags_d;
            flags_q      <= flags_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
        end
    end

    assign bus.instr_ready = (state_q == ST_IDLE);
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_fs      = alu_fs_q;
    assign busy_o          = (state_q != ST_IDLE);
    assign done_o          = done_q;
    assign flags_o         = flags_q;
    assign op_count_o      = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// Module   : tb_alu_sequencer
// Purpose  : Directed self-checking bench for alu_sequencer with a stub ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] rd_sel;
    logic [3:0] rd_data;
    logic [3:0] flags;
    logic       busy;
    logic       done;
    logic [7:0] op_count;
    logic       stub_sub;
    logic [3:0] stub_flags;
    int         n_total = 0;
    int         n_bad   = 0;

    always #5 clk = ~clk;

    alu_sequencer_if #(.DATA_W(4)) bus ();

    // Stub ALU: fixed result 8 / flags 0110, or a-b with N/Z derived from it
    assign bus.alu_y = stub_sub ? 4'(bus.alu_a - bus.alu_b) : 4'h8;
    always_comb begin
        stub_flags = 4'b0110;
        if (stub_sub) stub_flags = {2'b00, bus.alu_y[3], (bus.alu_y == 4'h0)};
    end
    assign bus.alu_c = stub_flags[FLAG_C];
    assign bus.alu_v = stub_flags[FLAG_V];
    assign bus.alu_n = stub_flags[FLAG_N];
    assign bus.alu_z = stub_flags[FLAG_Z];

    alu_sequencer #(
        .DATA_W   (4),
        .NUM_REGS (4),
        .CNT_W    (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .rd_sel_i   (rd_sel),
        .rd_data_o  (rd_data),
        .flags_o    (flags),
        .busy_o     (busy),
        .done_o     (done),
        .op_count_o (op_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] idx, input logic [3:0] exp);
        rd_sel = idx;
        #1;
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    function automatic logic [11:0] mk_alu(input logic [2:0] fs, input logic [1:0] rd,
                                           input logic [1:0] ra, input logic [1:0] rb);
        return {fs, 1'b0, rd, ra, rb, 2'b00};
    endfunction

    function automatic logic [11:0] mk_li(input logic [1:0] rd, input logic [3:0] imm);
        return {3'b000, 1'b1, rd, 2'b00, imm};
    endfunction

    // Present one instruction for exactly the accepting edge
    task automatic issue(input logic [11:0] ins);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        rd_sel          = 2'd0;
        stub_sub        = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        check("rst_ready", 32'(bus.instr_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_count", 32'(op_count), 32'd0);

        // Immediates
        issue(mk_li(2'd1, 4'h5));
        check("li1_busy", 32'(busy), 32'd1);
        check("li1_ready", 32'(bus.instr_ready), 32'd0);
        check("li1_done_early", 32'(done), 32'd0);
        tick();
        check("li1_done", 32'(done), 32'd1);
        check("li1_busy_after", 32'(busy), 32'd0);
        check_reg("li1_r1", 2'd1, 4'h5);
        issue(mk_li(2'd2, 4'h3));
        check("li2_done_gone", 32'(done), 32'd0);
        tick();
        check("li2_done", 32'(done), 32'd1);
        check_reg("li2_r2", 2'd2, 4'h3);
        check("li_flags", 32'(flags), 32'd0);
        check("li_count", 32'(op_count), 32'd2);
        check("li_alu_a_hold", 32'(bus.alu_a), 32'd0);
        tick();
        check("li2_done_1cyc", 32'(done), 32'd0);

        // ALU op with fixed stub result
        issue(mk_alu(FS_ADD, 2'd3, 2'd1, 2'd2));
        check("add_alu_a", 32'(bus.alu_a), 32'd5);
        check("add_alu_b", 32'(bus.alu_b), 32'd3);
        check("add_alu_fs", 32'(bus.alu_fs), 32'(FS_ADD));
        check("add_exec_done", 32'(done), 32'd0);
        tick();
        check("add_wb_done", 32'(done), 32'd0);
        check("add_wb_busy", 32'(busy), 32'd1);
        tick();
        check("add_done", 32'(done), 32'd1);
        check_reg("add_r3", 2'd3, 4'h8);
        check("add_flags", 32'(flags), 32'h6);
        check("add_count", 32'(op_count), 32'd3);

        // Aliased subtract: r1 = r1 - r1
        stub_sub = 1'b1;
        issue(mk_alu(FS_SUB, 2'd1, 2'd1, 2'd1));
        check("sub_alu_a", 32'(bus.alu_a), 32'd5);
        check("sub_alu_b", 32'(bus.alu_b), 32'd5);
        check("sub_alu_fs", 32'(bus.alu_fs), 32'(FS_SUB));
        tick();
        check_reg("sub_r1_pre", 2'd1, 4'h5);
        tick();
        check("sub_done", 32'(done), 32'd1);
        check_reg("sub_r1", 2'd1, 4'h0);
        check("sub_flags", 32'(flags), 32'h1);
        check("sub_count", 32'(op_count), 32'd4);

        // Backpressure: second instruction held valid while busy
        stub_sub = 1'b0;
        bus.instr       = mk_alu(FS_ADD, 2'd2, 2'd3, 2'd3);
        bus.instr_valid = 1'b1;
        tick();
        bus.instr = mk_li(2'd0, 4'hA);
        check("bp_exec_ready", 32'(bus.instr_ready), 32'd0);
        tick();
        check("bp_wb_ready", 32'(bus.instr_ready), 32'd0);
        tick();
        check("bp_first_done", 32'(done), 32'd1);
        check("bp_idle_ready", 32'(bus.instr_ready), 32'd1);
        check_reg("bp_r2", 2'd2, 4'h8);
        check_reg("bp_r0_not_yet", 2'd0, 4'h0);
        tick();
        bus.instr_valid = 1'b0;
        check("bp_second_accept", 32'(busy), 32'd1);
        check("bp_no_extra_done", 32'(done), 32'd0);
        tick();
        check("bp_second_done", 32'(done), 32'd1);
        check_reg("bp_r0", 2'd0, 4'hA);
        tick();
        tick();
        check("bp_count", 32'(op_count), 32'd6);
        check("bp_idle_done", 32'(done), 32'd0);

        // Reset while an instruction is in EXEC
        stub_sub = 1'b1;
        issue(mk_alu(FS_SUB, 2'd3, 2'd0, 2'd2));
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("mr_ready", 32'(bus.instr_ready), 32'd1);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_done", 32'(done), 32'd0);
        check("mr_flags", 32'(flags), 32'd0);
        check("mr_count", 32'(op_count), 32'd0);
        check("mr_alu_a", 32'(bus.alu_a), 32'd0);
        check("mr_alu_b", 32'(bus.alu_b), 32'd0);
        check("mr_alu_fs", 32'(bus.alu_fs), 32'd0);
        for (int i = 0; i < 4; i++) check_reg("mr_reg", 2'(i), 4'h0);
        tick();
        tick();
        check("mr_no_wb_done", 32'(done), 32'd0);
        check_reg("mr_no_wb_r3", 2'd3, 4'h0);

        // Counter wrap
        for (int i = 0; i < 255; i++) begin
            issue(mk_li(2'd1, 4'(i)));
            tick();
        end
        check("wrap_pre", 32'(op_count), 32'd255);
        check_reg("wrap_r1", 2'd1, 4'hE);
        issue(mk_li(2'd2, 4'h7));
        tick();
        check("wrap_done", 32'(done), 32'd1);
        check("wrap_count", 32'(op_count), 32'd0);
        check_reg("wrap_r2", 2'd2, 4'h7);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
